// File: rtl/mio_bus_responder_pkg.sv
// Shared constants and types for the CPU memory/IO bus responder:
// address map, timer control bits, FSM encoding and target decode.
package mio_bus_responder_pkg;

  localparam logic [31:0] ADDR_LED  = 32'hE000_0000;
  localparam logic [31:0] ADDR_SW   = 32'hF000_0000;
  localparam logic [31:0] ADDR_TCNT = 32'hF000_0004;
  localparam logic [31:0] ADDR_TCMP = 32'hF000_0008;
  localparam logic [31:0] ADDR_TCTL = 32'hF000_000C;

  localparam int TCTL_EN   = 0;
  localparam int TCTL_IRQ  = 1;
  localparam int TCTL_FLAG = 2;

  // Timer register index is the word offset (addr[3:2]) inside the timer block.
  localparam logic [1:0] TREG_TCNT = 2'd1;
  localparam logic [1:0] TREG_TCMP = 2'd2;
  localparam logic [1:0] TREG_TCTL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    TGT_RAM  = 3'd0,
    TGT_LED  = 3'd1,
    TGT_SW   = 3'd2,
    TGT_TMR  = 3'd3,
    TGT_NONE = 3'd4
  } tgt_e;

  // Full 32-bit decode; the byte-offset bits are masked off first.
  function automatic tgt_e decode_target(input logic [31:0] addr, input int ram_aw);
    logic [31:0] word;
    tgt_e        tgt;
    word = addr & 32'hFFFF_FFFC;
    if ((word >> (ram_aw + 2)) == 32'd0)
      tgt = TGT_RAM;
    else if (word == ADDR_LED)
      tgt = TGT_LED;
    else if (word == ADDR_SW)
      tgt = TGT_SW;
    else if (word == ADDR_TCNT || word == ADDR_TCMP || word == ADDR_TCTL)
      tgt = TGT_TMR;
    else
      tgt = TGT_NONE;
    return tgt;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// Compare timer: free-running TCNT, TCMP match sets a sticky flag,
// and cpu_int is the flag gated by irq_en.
module mio_timer
  import mio_bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_reg,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_reg,
  output logic [31:0] rd_data,
  output logic        cpu_int
);

  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic        count_en;
  logic        irq_en;
  logic        flag;
  logic        match;
  logic        wr_tcnt;
  logic        wr_tcmp;
  logic        wr_tctl;

  assign match   = count_en && (tcnt == tcmp);
  assign wr_tcnt = wr_en && (wr_reg == TREG_TCNT);
  assign wr_tcmp = wr_en && (wr_reg == TREG_TCMP);
  assign wr_tctl = wr_en && (wr_reg == TREG_TCTL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt     <= 32'd0;
      tcmp     <= 32'hFFFF_FFFF;
      count_en <= 1'b0;
      irq_en   <= 1'b0;
      flag     <= 1'b0;
    end else begin
      // A CPU write to TCNT overrides the increment in the same cycle.
      if (wr_tcnt)
        tcnt <= wr_data;
      else if (count_en)
        tcnt <= tcnt + 32'd1;
      if (wr_tcmp)
        tcmp <= wr_data;
      if (wr_tctl) begin
        count_en <= wr_data[TCTL_EN];
        irq_en   <= wr_data[TCTL_IRQ];
      end
      // A match landing with a write-1-to-clear keeps the flag set.
      if (match)
        flag <= 1'b1;
      else if (wr_tctl && wr_data[TCTL_FLAG])
        flag <= 1'b0;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_reg)
      TREG_TCNT: rd_data = tcnt;
      TREG_TCMP: rd_data = tcmp;
      TREG_TCTL: rd_data = {29'd0, flag, irq_en, count_en};
      default:   rd_data = 32'd0;
    endcase
  end

  assign cpu_int = flag && irq_en;

endmodule

// File: rtl/mio_bus_responder.sv
// Target end of the CPU memory/IO bus: decodes each access to RAM, LED,
// switches or the compare timer and answers with a one-cycle ready pulse.
module mio_bus_responder
  import mio_bus_responder_pkg::*;
#(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2,
  parameter int LED_W   = 16,
  parameter int SW_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_int,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   sw
);

  // Handshake: the CPU holds cpu_req (with we/addr/wdata stable) until it
  // sees cpu_ready; a request is accepted on the edge where the FSM is IDLE
  // and cpu_req is high, and cpu_ready is a single-cycle pulse in DONE.

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [RAM_AW-1:0]  word_q, word_d;
  logic [1:0]         reg_q, reg_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  tgt_e               tgt_q, tgt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [LED_W-1:0]   led_q;

  tgt_e               tgt_in;
  logic [31:0]        tmr_rd_data;
  logic [31:0]        periph_rd;
  logic               commit;

  assign tgt_in = decode_target(cpu_addr, RAM_AW);
  assign commit = (state_q == ST_DONE) && we_q;

  mio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (commit && (tgt_q == TGT_TMR)),
    .wr_reg  (reg_q),
    .wr_data (wdata_q),
    .rd_reg  (cpu_addr[3:2]),
    .rd_data (tmr_rd_data),
    .cpu_int (cpu_int)
  );

  always_comb begin
    periph_rd = 32'd0;
    case (tgt_in)
      TGT_LED: periph_rd = 32'(led_q);
      TGT_SW:  periph_rd = 32'(sw);
      TGT_TMR: periph_rd = tmr_rd_data;
      default: periph_rd = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    reg_d     = reg_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    tgt_d     = tgt_q;
    rdata_d   = rdata_q;
    ram_addr  = word_q;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    case (state_q)
      ST_IDLE: begin
        ram_addr = cpu_addr[RAM_AW+1:2];
        if (cpu_req) begin
          word_d  = cpu_addr[RAM_AW+1:2];
          reg_d   = cpu_addr[3:2];
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          tgt_d   = tgt_in;
          rdata_d = 32'd0;
          if (tgt_in == TGT_RAM && !cpu_we) begin
            cnt_d   = 3'(RAM_LAT - 1);
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DONE;
            if (tgt_in == TGT_RAM)
              ram_we = 1'b1;
            else if (!cpu_we)
              rdata_d = periph_rd;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = ram_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      word_q  <= '0;
      reg_q   <= 2'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      tgt_q   <= TGT_NONE;
      rdata_q <= 32'd0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      reg_q   <= reg_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      tgt_q   <= tgt_d;
      rdata_q <= rdata_d;
      if (commit && tgt_q == TGT_LED)
        led_q <= wdata_q[LED_W-1:0];
    end
  end

  assign cpu_ready = (state_q == ST_DONE);
  assign cpu_rdata = cpu_ready ? rdata_q : 32'd0;
  assign led       = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: driver tasks push expected
// responses into queues; a negedge monitor pops and compares on cpu_ready.
module tb_mio_bus_responder;

  localparam int RAM_AW  = 10;
  localparam int RAM_LAT = 2;
  localparam int LED_W   = 16;
  localparam int SW_W    = 16;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_int;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [LED_W-1:0]  led;
  logic [SW_W-1:0]   sw;

  mio_bus_responder #(
    .RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .LED_W(LED_W), .SW_W(SW_W)
  ) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_int(cpu_int), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .led(led), .sw(sw)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model (RAM_LAT = 2 pipeline) ----------------
  logic [31:0] mem [0:(1<<RAM_AW)-1];
  logic [31:0] pipe0, pipe1;
  initial for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = 32'd0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    pipe0 <= mem[ram_addr];
    pipe1 <= pipe0;
  end
  assign ram_rdata = pipe1;

  int                we_cnt = 0;
  logic [RAM_AW-1:0] we_addr = '0;
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= ram_addr;
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  int          lat_q[$];
  int          start_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cpu_ready && !reset) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'(cpu_ready), 32'd0);
        end else begin
          logic [31:0] e;
          bit          c;
          int          l;
          int          s;
          string       n;
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          l = lat_q.pop_front();
          s = start_q.pop_front();
          n = name_q.pop_front();
          if (c) check({n, "_rdata"}, cpu_rdata, e);
          check({n, "_latency"}, 32'(cyc - s), 32'(l));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a posedge with the FSM idle; returns just after the
  // edge that ends the DONE cycle (the commit edge), with cpu_req dropped.
  task automatic access(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp,
                        input bit chk, input int lat);
    bit seen;
    exp_q.push_back(exp);
    chk_q.push_back(chk);
    lat_q.push_back(lat);
    start_q.push_back(cyc);
    name_q.push_back(name);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cpu_ready) seen = 1'b1;
    end
    check({name, "_ready_seen"}, {31'd0, seen}, 32'd1);
    if (!seen) begin
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
      void'(lat_q.pop_back());
      void'(start_q.pop_back());
      void'(name_q.pop_back());
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data, input int lat);
    access(name, 1'b1, addr, data, 32'd0, 1'b0, lat);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp, input int lat);
    access(name, 1'b0, addr, 32'd0, exp, 1'b1, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_cpu_int"}, 32'(cpu_int), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int we_before;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    sw        = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Timer reset values
    rd("tcnt_reset", 32'hF000_0004, 32'd0, 1);
    rd("tcmp_reset", 32'hF000_0008, 32'hFFFF_FFFF, 1);
    rd("tctl_reset", 32'hF000_000C, 32'd0, 1);

    // RAM write / read with fixed latency
    wr("ram_wr10", 32'h0000_0010, 32'hDEAD_BEEF, 1);
    check("ram_we_count", 32'(we_cnt), 32'd1);
    check("ram_we_addr", 32'(we_addr), 32'd4);
    rd("ram_rd10", 32'h0000_0010, 32'hDEAD_BEEF, RAM_LAT + 1);
    wr("ram_wr_top", 32'h0000_0FFC, 32'h0BAD_F00D, 1);
    check("ram_top_addr", 32'(we_addr), 32'h3FF);
    rd("ram_rd_top", 32'h0000_0FFF, 32'h0BAD_F00D, RAM_LAT + 1);

    // LED / switches
    wr("led_wr", 32'hE000_0000, 32'h0000_A5A5, 1);
    check("led_value", 32'(led), 32'h0000_A5A5);
    rd("led_rd", 32'hE000_0000, 32'h0000_A5A5, 1);
    rd("sw_rd", 32'hF000_0000, 32'h0000_1234, 1);

    // Unmapped addresses, including the first word past RAM
    we_before = we_cnt;
    rd("unmapped_rd", 32'h1234_5678, 32'd0, 1);
    wr("unmapped_wr", 32'h1234_5678, 32'hFFFF_0000, 1);
    wr("past_ram_wr", 32'h0000_1000, 32'h5555_5555, 1);
    rd("past_ram_rd", 32'h0000_1000, 32'd0, 1);
    check("unmapped_no_ram_we", 32'(we_cnt), 32'(we_before));
    check("unmapped_led_kept", 32'(led), 32'h0000_A5A5);

    // Compare timer: flag rises 6 cycles after the TCTL commit edge
    wr("tcmp_wr5", 32'hF000_0008, 32'd5, 1);
    wr("tctl_wr3", 32'hF000_000C, 32'd3, 1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) check("int_before_match", 32'(cpu_int), 32'd0);
      if (k == 6) check("int_at_match", 32'(cpu_int), 32'd1);
    end

    // Clear coinciding with a match: tcnt 998 after commit, 999 in DONE
    wr("tcmp_wr999", 32'hF000_0008, 32'd999, 1);
    wr("tcnt_wr998", 32'hF000_0004, 32'd998, 1);
    wr("tctl_clr_race", 32'hF000_000C, 32'd7, 1);
    check("int_set_wins", 32'(cpu_int), 32'd1);
    rd("tctl_flag_set", 32'hF000_000C, 32'd7, 1);
    wr("tctl_clr", 32'hF000_000C, 32'd7, 1);
    check("int_cleared", 32'(cpu_int), 32'd0);
    rd("tctl_flag_clr", 32'hF000_000C, 32'd3, 1);

    // Counter wrap
    wr("tcnt_wr_max", 32'hF000_0004, 32'hFFFF_FFFF, 1);
    @(posedge clk);
    #1;
    rd("tcnt_wrapped", 32'hF000_0004, 32'd0, 1);
    check("wrap_no_flag", 32'(cpu_int), 32'd0);

    // Reset during WAIT of a RAM read
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    cpu_req = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd("ram_after_reset", 32'h0000_0010, 32'hDEAD_BEEF, RAM_LAT + 1);
    rd("tcmp_after_reset", 32'hF000_0008, 32'hFFFF_FFFF, 1);
    rd("led_after_reset", 32'hE000_0000, 32'd0, 1);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
